// File: rtl/readout_pkg.sv
// readout_pkg: state encoding and framing constants shared by the readout sequencer
package readout_pkg;
   typedef enum logic [2:0] {IDLE, LOAD, HEADER, FNUM, STREAM, TRAILER} state_t;
   localparam logic [7:0]  HDR_MARK       = 8'hFE;
   localparam logic [15:0] TRAILER_WORD   = 16'h0FED;
   localparam logic [15:0] DEFAULT_PERIOD = 16'h00E5;
endpackage

// File: rtl/readout_sequencer_timer.sv
// interval_timer: integration window timer; a period load restarts the window and swallows a coincident tick
module interval_timer
   import readout_pkg::*;
#(
   parameter int TW = 16
)(
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        enable_i,
   input  logic [15:0] period_i,
   input  logic        period_ld_i,
   output logic        tick_o
);
   logic [15:0]    period_reg;
   logic [TW+15:0] timer;
   assign tick_o = enable_i && !period_ld_i && timer == {period_reg, {TW{1'b1}}};
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         period_reg <= DEFAULT_PERIOD;
         timer      <= '0;
      end else if (period_ld_i) begin
         period_reg <= period_i;
         timer      <= '0;
      end else if (tick_o)
         timer <= '0;
      else if (enable_i)
         timer <= timer + 1'b1;
   end
endmodule

// File: rtl/readout_sequencer.sv
// readout_sequencer: windowed readout of NCH counter chains into one FIFO port; READOUT_FRAMECOUNT_EN adds a frame-number word
module readout_sequencer
   import readout_pkg::*;
#(
   parameter int NCH   = 2,
   parameter int NBINS = 26,
   parameter int TW    = 16
)(
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              enable_i,
   input  logic [15:0]       period_i,
   input  logic              period_ld_i,
   input  logic              fifo_ready_i,
   input  logic [16*NCH-1:0] ch_data_i,
   output logic [NCH-1:0]    ch_ld_o,
   output logic [NCH-1:0]    clear_o,
   output logic [15:0]       data_o,
   output logic              wr_o,
   output logic              busy_o,
   output logic              overrun_o
);
   localparam int CHW = NCH > 1 ? $clog2(NCH) : 1;
   localparam int CW  = $clog2(NBINS + 1);
   state_t         state, state_n, hdr_next;
   logic [CHW-1:0] ch;
   logic [CW-1:0]  cnt;
   logic [15:0]    cap, stream_word, fnum_word;
   logic [15:0]    chw [NCH];
   logic [NCH-1:0] sel;
   logic           tick, clr_all, last_ch, last_bin;

   interval_timer #(.TW(TW)) u_timer (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .enable_i    (enable_i),
      .period_i    (period_i),
      .period_ld_i (period_ld_i),
      .tick_o      (tick)
   );

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      assign chw[i] = ch_data_i[16*i +: 16];
   end

   assign sel      = NCH'(1) << ch;
   assign last_ch  = ch == CHW'(NCH - 1);
   assign last_bin = cnt == CW'(NBINS - 1);

   // the chain shifts on its own after load, so the frame word delays the capture by one more stage
`ifdef READOUT_FRAMECOUNT_EN
   logic [15:0] frame, cap_d;
   always_ff @(posedge clk_i) begin
      cap_d <= cap;
      frame <= reset_i ? '0 : (state == TRAILER && last_ch) ? frame + 1'b1 : frame;
   end
   assign stream_word = cap_d;
   assign fnum_word   = frame;
   assign hdr_next    = FNUM;
`else
   assign stream_word = cap;
   assign fnum_word   = '0;
   assign hdr_next    = STREAM;
`endif

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state     <= IDLE;
         ch        <= '0;
         cnt       <= '0;
         clr_all   <= 1'b0;
         overrun_o <= 1'b0;
      end else begin
         state     <= state_n;
         ch        <= state == IDLE ? '0 : state == TRAILER ? ch + 1'b1 : ch;
         cnt       <= state == STREAM ? cnt + 1'b1 : '0;
         clr_all   <= period_ld_i;
         overrun_o <= period_ld_i ? 1'b0 : (tick && (state != IDLE || !fifo_ready_i)) ? 1'b1 : overrun_o;
      end
   end

   always_ff @(posedge clk_i) cap <= {chw[ch][7:0], chw[ch][15:8]};

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = tick && fifo_ready_i ? LOAD : IDLE;
         LOAD:    state_n = HEADER;
         HEADER:  state_n = hdr_next;
         FNUM:    state_n = STREAM;
         STREAM:  state_n = last_bin ? TRAILER : STREAM;
         TRAILER: state_n = last_ch ? IDLE : LOAD;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      ch_ld_o = state == LOAD ? sel : '0;
      clear_o = (state == HEADER ? sel : '0) | {NCH{clr_all}};
      wr_o    = state inside {HEADER, FNUM, STREAM, TRAILER};
      busy_o  = state != IDLE;
      data_o  = state == HEADER  ? {HDR_MARK, 8'(ch)} :
                state == FNUM    ? fnum_word :
                state == STREAM  ? stream_word :
                state == TRAILER ? TRAILER_WORD : '0;
   end
endmodule

// File: tb/tb_readout_sequencer.sv
// tb_readout_sequencer: frame-schedule model plus literal pins, run with a 2^8-cycle window unit
module tb_readout_sequencer;
   localparam int NCH = 2, NBINS = 4, TW = 8, MAXC = 4096;
`ifdef READOUT_FRAMECOUNT_EN
   localparam int FC = 1;
`else
   localparam int FC = 0;
`endif
   localparam int STRIDE = NBINS + 3 + FC;

   logic              clk = 1'b0;
   logic              reset_i, enable_i, period_ld_i, fifo_ready_i;
   logic [15:0]       period_i;
   logic [16*NCH-1:0] ch_data_i;
   logic [NCH-1:0]    ch_ld_o, clear_o;
   logic [15:0]       data_o;
   logic              wr_o, busy_o, overrun_o;

   readout_sequencer #(.NCH(NCH), .NBINS(NBINS), .TW(TW)) dut (
      .clk_i(clk), .reset_i(reset_i), .enable_i(enable_i), .period_i(period_i),
      .period_ld_i(period_ld_i), .fifo_ready_i(fifo_ready_i), .ch_data_i(ch_data_i),
      .ch_ld_o(ch_ld_o), .clear_o(clear_o), .data_o(data_o), .wr_o(wr_o),
      .busy_o(busy_o), .overrun_o(overrun_o)
   );

   always #5 clk = ~clk;

   int             cyc = 0, n_cmp = 0, n_bad = 0, mode = 0, s0 = 0, nb = 0;
   int             ld_at [NCH];
   bit             chk_on = 1'b0, m_ovr = 1'b0, m_tick = 1'b0;
   longint         tmr = 0;
   logic [15:0]    per = 16'h00E5, fnum = 16'h0;
   bit [NCH-1:0]   e_ld [MAXC], e_clr [MAXC];
   bit             e_wr [MAXC], e_busy [MAXC];
   bit [15:0]      e_data [MAXC];

   function automatic logic [15:0] word(int k, int i);
      return mode == 0 ? 16'h1234 : 16'(32'hA000 + k * 256 + i * 37 + 5);
   endfunction

   task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic sched(int t);
      logic [15:0] w;
      int c;
      for (int k = 0; k < NCH; k++) begin
         c = t + 1 + k * STRIDE;
         e_ld[c] = NCH'(1) << k;
         e_clr[c+1] |= NCH'(1) << k;
         e_data[c+1] = {8'hFE, 8'(k)};
         if (FC == 1) e_data[c+2] = fnum;
         for (int i = 0; i < NBINS; i++) begin
            w = word(k, i);
            e_data[c+2+FC+i] = {w[7:0], w[15:8]};
         end
         e_data[c+2+FC+NBINS] = 16'h0FED;
         for (int j = 1; j <= NBINS + 2 + FC; j++) e_wr[c+j] = 1'b1;
         for (int j = 0; j < STRIDE; j++) e_busy[c+j] = 1'b1;
      end
      fnum = fnum + 16'h1;
   endtask

   // model: window arithmetic decides ticks, each accepted tick lays out a whole frame ahead in time
   initial forever begin
      @(posedge clk);
      if (reset_i) begin
         tmr = 0; per = 16'h00E5; m_ovr = 1'b0; fnum = 16'h0;
         for (int c = cyc + 1; c < MAXC; c++) begin
            e_ld[c] = '0; e_clr[c] = '0; e_wr[c] = 1'b0; e_busy[c] = 1'b0; e_data[c] = '0;
         end
      end else begin
         m_tick = enable_i && !period_ld_i && tmr == ((longint'(per) + 1) << TW) - 1;
         if (period_ld_i) begin
            per = period_i; tmr = 0; m_ovr = 1'b0;
            e_clr[cyc+1] = '1;
         end else if (m_tick) tmr = 0;
         else if (enable_i) tmr++;
         if (m_tick) begin
            if (e_busy[cyc] || !fifo_ready_i) m_ovr = 1'b1;
            else sched(cyc);
         end
      end
      cyc++;
   end

   // counter chain: after a load, word i is presented in the (i+1)-th following cycle
   initial begin
      for (int k = 0; k < NCH; k++) ld_at[k] = -100;
      forever begin
         @(negedge clk);
         for (int k = 0; k < NCH; k++) begin
            if (ch_ld_o[k] === 1'b1) ld_at[k] = cyc;
            ch_data_i[16*k +: 16] = (cyc - ld_at[k] - 1) inside {[0:NBINS-1]} ? word(k, cyc - ld_at[k] - 1) : 16'hDEAD;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (chk_on) begin
         chk("ch_ld_o", 16'(ch_ld_o), 16'(e_ld[cyc]));
         chk("clear_o", 16'(clear_o), 16'(e_clr[cyc]));
         chk("wr_o", 16'(wr_o), 16'(e_wr[cyc]));
         chk("busy_o", 16'(busy_o), 16'(e_busy[cyc]));
         chk("overrun_o", 16'(overrun_o), 16'(m_ovr));
         if (e_wr[cyc]) chk("data_o", data_o, e_data[cyc]);
      end
   end

   task automatic wait_cyc(int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic at(int off);
      wait_cyc(s0 + off);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      reset_i = 1'b1; enable_i = 1'b0; period_i = 16'h0; period_ld_i = 1'b0; fifo_ready_i = 1'b1;
      wait_cyc(1);
      chk_on = 1'b1;
      wait_cyc(2);
      chk("rst_busy", 16'(busy_o), 16'h0);
      chk("rst_wr", 16'(wr_o), 16'h0);
      chk("rst_clear", 16'(clear_o), 16'h0);
      chk("rst_ovr", 16'(overrun_o), 16'h0);
      wait_cyc(4);
      reset_i = 1'b0; enable_i = 1'b1; period_ld_i = 1'b1; period_i = 16'h0; s0 = cyc;
      at(1); period_ld_i = 1'b0;
      chk("pld_clear_all", 16'(clear_o), 16'h3);
      for (int c = 250; c <= 272; c++) begin
         at(c);
         nb += int'(busy_o);
         case (c)
            256: chk("no_ld_before_tick", 16'(ch_ld_o), 16'h0);
            257: chk("ld_ch0", 16'(ch_ld_o), 16'h1);
            258: begin chk("hdr0", data_o, 16'hFE00); chk("clr_hdr0", 16'(clear_o), 16'h1); end
            259: chk("w0_swapped", data_o, 16'h3412);
            262: chk("w3_swapped", data_o, 16'h3412);
            263: chk("trl0", data_o, 16'h0FED);
            264: begin chk("ld_ch1", 16'(ch_ld_o), 16'h2); chk("gap_wr", 16'(wr_o), 16'h0); end
            265: begin chk("hdr1", data_o, 16'hFE01); chk("clr_hdr1", 16'(clear_o), 16'h2); end
            270: chk("trl1", data_o, 16'h0FED);
            default: ;
         endcase
      end
      chk("busy_len", 16'(nb), 16'd14);
      at(300); mode = 1;
      at(700); fifo_ready_i = 1'b0;
      at(769); chk("skip_no_ld", 16'(ch_ld_o), 16'h0);
      at(770); chk("skip_overrun", 16'(overrun_o), 16'h1); chk("skip_no_clear", 16'(clear_o), 16'h0);
      at(800); fifo_ready_i = 1'b1;
      at(1025); chk("resume_ld", 16'(ch_ld_o), 16'h1); chk("ovr_sticky", 16'(overrun_o), 16'h1);
      at(1030); period_ld_i = 1'b1; period_i = 16'h1;
      at(1031); period_ld_i = 1'b0;
      chk("mid_clear_all", 16'(clear_o), 16'h3);
      at(1032); chk("mid_ovr_cleared", 16'(overrun_o), 16'h0); chk("mid_clear_once", 16'(clear_o), 16'h0);
      at(1038); chk("mid_frame_trl", data_o, 16'h0FED);
      at(1543); chk("p1_window_ld", 16'(ch_ld_o), 16'h1);
      at(2054); period_ld_i = 1'b1; period_i = 16'h0;
      at(2055); period_ld_i = 1'b0; chk("coinc_no_frame", 16'(busy_o), 16'h0);
      at(2311); chk("coinc_next_ld", 16'(ch_ld_o), 16'h1);
      at(2313); enable_i = 1'b0;
      at(2320); chk("disable_frame_runs", 16'(busy_o), 16'h1);
      at(2333); enable_i = 1'b1;
      at(2587); chk("hold_then_tick_ld", 16'(ch_ld_o), 16'h1);
      at(2590); reset_i = 1'b1;
      at(2591); chk("rst_mid_busy", 16'(busy_o), 16'h0); chk("rst_mid_wr", 16'(wr_o), 16'h0);
      at(2592); reset_i = 1'b0; period_ld_i = 1'b1; period_i = 16'h0;
      at(2593); period_ld_i = 1'b0;
      at(2849); chk("post_rst_ld", 16'(ch_ld_o), 16'h1);
      at(2900);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
